prg_stream_gen: RTL
===================

# prg_stream_gen

- Multi-channel Boolean pseudo-random bit generator.
- Holds CHANNELS Galois LFSRs of parametrised width and combines their output bits with a selectable Boolean function.
- Packs the combined bitstream into OUT_W-bit words and delivers them over a valid/ready stream.
- Successor to the fixed-width generator in the tt_um_prg top level; sits between the top-level IO mapping and any consumer of random words.

## Interface
Parameters:
- WIDTH, 16, LFSR width; legal values 8/16/24/32, anything else is an elaboration error.
- CHANNELS, 3, number of LFSR channels, 1..4.
- OUT_W, 8, output word width, 2..WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enables stepping.
- mode  in  2  combining function select.
- seed_we  in  1  seed write strobe, always accepted.
- seed_ch  in  2  target channel for the seed write.
- seed_data  in  WIDTH  seed value.
- out_data  out  OUT_W  output word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word.
- zero_fixed  out  1  one-cycle pulse when an all-zero seed was replaced.

## Operation
- Channel step (Galois, right shift):
  - Channel bit b = s[0] before the step.
  - s_next = (s >> 1) ^ (b ? POLY : 0).
  - POLY comes from the package mask for WIDTH.
- Combined bit, from channel bits b0..b(CHANNELS-1):
  - mode 0: XOR of all channel bits.
  - mode 1: b0 only.
  - mode 2: majority(b0, b1, b2).
  - mode 3: Geffe, b0 ? b1 : b2.
  - Modes 2 and 3 with CHANNELS < 3 behave as mode 0.
- mode is sampled on every step; changing it mid-word is legal.
- Packer: the combined bit of the k-th step since word start goes to packer bit k (LSB first). The packer keeps a count, 0..OUT_W-1.
- Step condition: run && !seed_we && !stall.
  - All channels step together.
  - stall = (count == OUT_W-1) && out_valid && !out_ready.
- Word completion: on the step where count == OUT_W-1:
  - {new bit, packer} loads out_data.
  - out_valid is set.
  - count returns to 0.
- Output handshake: a word is consumed when out_valid && out_ready.
  - out_valid clears unless a new word loads in the same cycle.
  - A load and a consume in the same cycle are legal; there is no bubble.
  - out_data is held stable while out_valid && !out_ready.
- Seed write (seed_we):
  - seed_data is written to channel seed_ch.
  - No channel steps that cycle.
  - count clears to 0 and the partial word is discarded.
  - The output register is untouched.
- Zero seed: an all-zero seed_data is stored as 1, and zero_fixed pulses high in the next cycle.
- seed_ch >= CHANNELS: the write is ignored and neither the state nor count changes.
- Lock-up is impossible: states never reach 0, because the polynomials are maximal length and zero seeds are replaced.

## Timing
- Reset values:
  - channel c state = c+1.
  - count = 0.
  - out_data = 0.
  - out_valid = 0.
  - zero_fixed = 0.
- rst overrides seed_we and run in the same cycle.
- Reset mid-word discards the packer and output contents.
- Steady throughput: one word per OUT_W cycles while run is high and the consumer is ready.
- Latency:
  - First step in the cycle run is high (after any seed write).
  - The OUT_W-th step is at cycle t+OUT_W-1.
  - out_valid is high from t+OUT_W.
- During a stall, LFSR states and count freeze. Stepping resumes in the cycle the consumer accepts.
- zero_fixed is registered, so it is high exactly one cycle after the write.

## Structure
- Package prg_pkg holds:
  - function lfsr_poly(width): 8→8'hB8, 16→16'hB400, 24→24'hE10000, 32→32'hA3000000.
  - Mode constants: MODE_XOR, MODE_RAW, MODE_MAJ, MODE_GEFFE.
  - Reset-seed rule.
- Sub-module prg_lfsr: one channel with state register, step enable, load enable and zero replacement. Instantiated CHANNELS times.
- The combiner, packer and output register live in prg_stream_gen.

## Test plan
All tests use WIDTH=16, CHANNELS=3, OUT_W=8.
1. Reset, then run=1, mode=1, out_ready=1 → first word 0x01 with out_valid high 8 cycles after run rises; out_valid stays 0 before that.
2. Seed ch0=0xACE1, then run=1, mode=1 → first word 0xE1; ch0 state after 8 steps is 0xC2C4, observed through the next word.
3. mode=1, run=1, out_ready=0 for 20 cycles → out_data holds the first word. The packer stalls at count 7 and states freeze. On out_ready=1: the first word is consumed, the second word loads the same cycle, and valid is never dropped.
4. Seed ch1 = 0 → stored as 0x0001; zero_fixed high exactly one cycle; seed_ch=3 write has no effect and no pulse.
5. Seed write at count 4 mid-word → partial bits discarded; the next word consists entirely of post-seed bits; a pending out_data is unchanged.
6. rst asserted mid-word with out_valid high → next cycle out_valid=0, out_data=0, and the sequence restarts identically to scenario 1.

Source files
------------

// File: rtl/prg_pkg.sv
// Shared constants for the multi-channel pseudo-random stream generator:
// LFSR feedback masks, combining-mode encoding and the reset-seed rule.
package prg_pkg;

  typedef enum logic [1:0] {
    MODE_XOR   = 2'd0,
    MODE_RAW   = 2'd1,
    MODE_MAJ   = 2'd2,
    MODE_GEFFE = 2'd3
  } prg_mode_e;

  // Maximal-length Galois (right-shift) feedback masks; 0 marks an unsupported width.
  function automatic logic [31:0] lfsr_poly(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      24:      return 32'h00E1_0000;
      32:      return 32'hA300_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic bit width_legal(input int width);
    return (width == 8) || (width == 16) || (width == 24) || (width == 32);
  endfunction

  // Channel c wakes up holding c+1, so no two channels start identical and none is zero.
  function automatic logic [31:0] reset_seed(input int ch);
    return 32'(ch + 1);
  endfunction

endpackage

// File: rtl/prg_stream_gen_if.sv
// Output word stream of prg_stream_gen.
// A word transfers on every rising edge where out_valid && out_ready; while out_valid is
// high and out_ready low the producer holds out_data stable and never withdraws out_valid.
interface prg_stream_gen_if #(
  parameter int OUT_W = 8
) ();
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/prg_lfsr.sv
// One Galois LFSR channel: steps right with feedback mask, takes seed loads and
// replaces an all-zero seed with 1 so the register can never lock up.
module prg_lfsr
  import prg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] state,
  output logic             out_bit
);

  localparam logic [31:0]      POLY_FULL = lfsr_poly(WIDTH);
  localparam logic [31:0]      SEED_FULL = reset_seed(CH);
  localparam logic [WIDTH-1:0] POLY      = POLY_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED      = SEED_FULL[WIDTH-1:0];

  assign out_bit = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_data == '0) ? WIDTH'(1) : load_data;
    end else if (step) begin
      state <= (state >> 1) ^ (state[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/prg_stream_gen.sv
// Multi-channel Boolean pseudo-random generator: combines CHANNELS LFSR bits per step,
// packs them LSB-first into OUT_W-bit words and offers each word on a valid/ready stream.
module prg_stream_gen
  import prg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 3,
  parameter int OUT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [1:0]              mode,
  input  logic                    seed_we,
  input  logic [1:0]              seed_ch,
  input  logic [WIDTH-1:0]        seed_data,
  prg_stream_gen_if.master        strm,
  output logic                    zero_fixed
);

  localparam int CW = $clog2(OUT_W);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("prg_stream_gen: WIDTH must be 8, 16, 24 or 32");
  end
  if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
    $error("prg_stream_gen: CHANNELS must be 1..4");
  end
  if (OUT_W < 2 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("prg_stream_gen: OUT_W must be 2..WIDTH");
  end

  logic [CHANNELS-1:0] ch_bits;
  logic [CW-1:0]       count;
  logic [OUT_W-2:0]    pack;
  logic [OUT_W-1:0]    data_q;
  logic                valid_q;
  logic                last;
  logic                stall;
  logic                step;
  logic                seed_hit;
  logic                comb_bit;

  assign last     = (count == CW'(OUT_W - 1));
  assign stall    = last && valid_q && !strm.out_ready;
  assign step     = run && !seed_we && !stall;
  assign seed_hit = seed_we && (int'(seed_ch) < CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] st;
    prg_lfsr #(.WIDTH(WIDTH), .CH(c)) u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .load      (seed_we && (seed_ch == 2'(c))),
      .load_data (seed_data),
      .state     (st),
      .out_bit   (ch_bits[c])
    );
  end

  // Majority and Geffe need three inputs; narrower builds fall back to XOR.
  always_comb begin
    logic [3:0] bx;
    logic       xor_bit;
    logic       maj_bit;
    logic       geffe_bit;
    bx                 = '0;
    bx[CHANNELS-1:0]   = ch_bits;
    xor_bit            = ^ch_bits;
    maj_bit            = (bx[0] & bx[1]) | (bx[0] & bx[2]) | (bx[1] & bx[2]);
    geffe_bit          = bx[0] ? bx[1] : bx[2];
    comb_bit           = xor_bit;
    case (prg_mode_e'(mode))
      MODE_RAW:   comb_bit = bx[0];
      MODE_MAJ:   comb_bit = (CHANNELS >= 3) ? maj_bit : xor_bit;
      MODE_GEFFE: comb_bit = (CHANNELS >= 3) ? geffe_bit : xor_bit;
      default:    comb_bit = xor_bit;
    endcase
  end

  // A seed write restarts the word so the next word contains only post-seed bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (seed_hit) begin
      count <= '0;
    end else if (step) begin
      count <= last ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack <= '0;
    end else if (step && !last) begin
      for (int i = 0; i < OUT_W - 1; i++) begin
        if (count == CW'(i)) pack[i] <= comb_bit;
      end
    end
  end

  // A load in the same cycle as a consume keeps valid high, so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (step && last) begin
      data_q  <= {comb_bit, pack};
      valid_q <= 1'b1;
    end else if (valid_q && strm.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_fixed <= 1'b0;
    end else begin
      zero_fixed <= seed_hit && (seed_data == '0);
    end
  end

  assign strm.out_data  = data_q;
  assign strm.out_valid = valid_q;

endmodule
